// File: rtl/ecies_cipher_serializer_if.sv
// Output stream bundle of the ECIES cipher serializer: data word, valid/ready
// handshake and first/last frame markers.
interface ecies_cipher_serializer_if #(
  parameter int word_width = 32
);
  logic [word_width-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_first;
  logic                  out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_first,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_first,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/ecies_cipher_serializer.sv
// Captures the ECIES ciphertext bundle {Rx, Ry, msg, tag} on the rising edge of
// cipher_done and streams it as one header word plus MSB-first payload words.
module ecies_cipher_serializer #(
  parameter int message_width = 32,
  parameter int integer_size  = 64,
  parameter int hashed_width  = 512,
  parameter int word_width    = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic cipher_done,
  input  logic [message_width+2*integer_size+hashed_width-1:0] full_cipher,
  ecies_cipher_serializer_if.master out_if,
  output logic busy,
  output logic frame_done,
  output logic overrun,
  input  logic clear_err
);

  localparam int CIPHER_W  = message_width + 2*integer_size + hashed_width;
  localparam int NUM_WORDS = (CIPHER_W + word_width - 1) / word_width;
  localparam int SR_W      = NUM_WORDS * word_width;
  localparam int PAD_W     = SR_W - CIPHER_W;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);

  localparam logic [15:0]           BYTE_CNT = 16'(SR_W / 8);
  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [word_width-1:0] HDR_WORD = word_width'({16'hEC1E, BYTE_CNT});

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;

  // Left-justify the bundle so the short final word carries zeros in its LSBs.
  function automatic logic [SR_W-1:0] align_msb(input logic [CIPHER_W-1:0] b);
    return SR_W'(b) << PAD_W;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              cipher_done_q;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
  logic              start;
  logic              xfer;
  logic              valid_w;
  logic [word_width-1:0] out_data_w;

  always_comb begin
    start        = cipher_done & ~cipher_done_q;
    valid_w      = (state_q != S_IDLE);
    xfer         = valid_w & out_if.out_ready;
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    frame_done_d = 1'b0;

    // Set has priority over clear so a completion dropped in the clearing cycle is not lost.
    overrun_d = overrun_q;
    if (clear_err)                   overrun_d = 1'b0;
    if (start && state_q != S_IDLE)  overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = align_msb(full_cipher);
          cnt_d   = '0;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (xfer) state_d = S_DATA;
      end
      S_DATA: begin
        if (xfer) begin
          sr_d  = sr_q << word_width;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_data_w = '0;
    case (state_q)
      S_HEADER: out_data_w = HDR_WORD;
      S_DATA:   out_data_w = sr_q[SR_W-1 -: word_width];
      default:  out_data_w = '0;
    endcase
  end

  // ---- control register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cipher_done_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cipher_done_q <= cipher_done;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
    end
  end

  // ---- payload register stage ----
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign out_if.out_data  = out_data_w;
  assign out_if.out_valid = valid_w;
  assign out_if.out_first = (state_q == S_HEADER);
  assign out_if.out_last  = (state_q == S_DATA) && (cnt_q == LAST_IDX);
  assign busy             = valid_w;
  assign frame_done       = frame_done_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_ecies_cipher_serializer.sv
// Randomized bench for ecies_cipher_serializer: default build plus a padded
// 64-bit-word build, both checked against a bit-level frame model.
module tb_ecies_cipher_serializer;

  localparam int CW   = 672;
  localparam int WW   = 32;
  localparam int P_CW = 416;
  localparam int P_WW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic cipher_done, clear_err, busy, frame_done, overrun;
  logic [CW-1:0] full_cipher;
  logic p_cipher_done, p_clear_err, p_busy, p_frame_done, p_overrun;
  logic [P_CW-1:0] p_full;

  ecies_cipher_serializer_if #(.word_width(WW))   s_if ();
  ecies_cipher_serializer_if #(.word_width(P_WW)) p_if ();

  ecies_cipher_serializer dut (
    .clk(clk), .rst(rst), .cipher_done(cipher_done), .full_cipher(full_cipher),
    .out_if(s_if), .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .clear_err(clear_err)
  );

  ecies_cipher_serializer #(.hashed_width(256), .word_width(64)) dut_pad (
    .clk(clk), .rst(rst), .cipher_done(p_cipher_done), .full_cipher(p_full),
    .out_if(p_if), .busy(p_busy), .frame_done(p_frame_done), .overrun(p_overrun),
    .clear_err(p_clear_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer log of the default build, sampled on the falling edge.
  logic [WW-1:0] mw[$];
  bit            mf[$];
  bit            ml[$];
  int            mc[$];
  int            fd_cyc[$];
  int            stall_bad = 0;
  bit            prev_stall = 1'b0;
  logic [WW-1:0] prev_data;
  bit            prev_first, prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!s_if.out_valid || s_if.out_data !== prev_data ||
                         s_if.out_first !== prev_first || s_if.out_last !== prev_last))
        stall_bad <= stall_bad + 1;
      if (s_if.out_valid && s_if.out_ready) begin
        mw.push_back(s_if.out_data);
        mf.push_back(s_if.out_first);
        ml.push_back(s_if.out_last);
        mc.push_back(cyc);
      end
      if (frame_done) fd_cyc.push_back(cyc);
      prev_stall <= s_if.out_valid && !s_if.out_ready;
      prev_data  <= s_if.out_data;
      prev_first <= s_if.out_first;
      prev_last  <= s_if.out_last;
    end
  end

  // Payload word k: bit g (counted from the bundle MSB) of the frame, zero past the end.
  function automatic logic [63:0] model_word(input logic [1023:0] b, input int cw,
                                             input int w, input int k);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < w; j++) begin
      int g;
      g = k * w + j;
      if (g < cw) r[w-1-j] = b[cw-1-g];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mw.delete(); mf.delete(); ml.delete(); mc.delete(); fd_cyc.delete();
  endtask

  task automatic rand_bundle(output logic [CW-1:0] b);
    for (int i = 0; i < CW / 32; i++) b[i*32 +: 32] = $urandom();
  endtask

  task automatic wait_fd(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (fd_cyc.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cipher_done = 1'b0; clear_err = 1'b0; full_cipher = '0;
    p_cipher_done = 1'b0; p_clear_err = 1'b0; p_full = '0;
    s_if.out_ready = 1'b1; p_if.out_ready = 1'b1;
    repeat (3) tick();
    n_checks++; if (s_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", s_if.out_valid); end
    n_checks++; if (s_if.out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", s_if.out_data); end
    n_checks++; if ({s_if.out_first, s_if.out_last} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {s_if.out_first, s_if.out_last}); end
    n_checks++; if ({busy, frame_done, overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", {busy, frame_done, overrun}); end
    rst = 1'b0;
    repeat (2) tick();
    clear_mon();
  endtask

  task automatic test_frame_ordering();
    logic [CW-1:0] b;
    logic [63:0]   m;
    logic [33:0]   exp_w;
    bit            ok;
    int            e;
    b = {{8{8'h11}}, {8{8'h22}}, 32'hDEADBEEF, {64{8'hA5}}};
    clear_mon();
    s_if.out_ready = 1'b1;
    cipher_done = 1'b1; full_cipher = b; e = cyc;
    wait_fd(100, ok);
    repeat (3) tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL order_timeout: got no frame_done want frame_done"); end
    n_checks++; if (mw.size() !== 22) begin n_fail++; $display("FAIL order_count: got %0d want 22", mw.size()); end
    if (mw.size() == 22) begin
      n_checks++; if (mc[0] !== e + 1) begin n_fail++; $display("FAIL order_latency: got cycle %0d want %0d", mc[0], e + 1); end
      n_checks++; if (mc[21] !== mc[0] + 21) begin n_fail++; $display("FAIL order_back_to_back: got span %0d want 21", mc[21] - mc[0]); end
      n_checks++; if (mw[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL order_msg_word: got %h want deadbeef", mw[5]); end
      for (int i = 0; i < 22; i++) begin
        m = model_word(1024'(b), CW, WW, i - 1);
        exp_w = {i == 0, i == 21, (i == 0) ? 32'hEC1E0054 : m[31:0]};
        n_checks++; if ({mf[i], ml[i], mw[i]} !== exp_w) begin n_fail++; $display("FAIL order_word%0d: got %h want %h", i, {mf[i], ml[i], mw[i]}, exp_w); end
      end
      n_checks++; if (fd_cyc.size() !== 1 || fd_cyc[0] !== mc[21] + 1) begin n_fail++; $display("FAIL order_frame_done: got %0d pulses first at %0d want 1 at %0d", fd_cyc.size(), fd_cyc[0], mc[21] + 1); end
    end
    cipher_done = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_back_pressure();
    logic [CW-1:0] b;
    logic [63:0]   m;
    logic [33:0]   exp_w;
    int            base;
    bit            ok;
    rand_bundle(b);
    clear_mon();
    base = stall_bad;
    ok = 1'b0;
    cipher_done = 1'b1; full_cipher = b; s_if.out_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < 400; i++) begin
      tick();
      s_if.out_ready = 1'($urandom_range(0, 1));
      full_cipher[31:0] = $urandom();
      if (fd_cyc.size() > 0) begin ok = 1'b1; break; end
    end
    s_if.out_ready = 1'b1;
    tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no frame_done want frame_done"); end
    n_checks++; if (stall_bad !== base) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad - base); end
    n_checks++; if (mw.size() !== 22) begin n_fail++; $display("FAIL bp_count: got %0d want 22", mw.size()); end
    if (mw.size() == 22) begin
      for (int i = 0; i < 22; i++) begin
        m = model_word(1024'(b), CW, WW, i - 1);
        exp_w = {i == 0, i == 21, (i == 0) ? 32'hEC1E0054 : m[31:0]};
        n_checks++; if ({mf[i], ml[i], mw[i]} !== exp_w) begin n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, {mf[i], ml[i], mw[i]}, exp_w); end
      end
    end
    cipher_done = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_held_level();
    logic [CW-1:0] b;
    rand_bundle(b);
    clear_mon();
    s_if.out_ready = 1'b1;
    cipher_done = 1'b1; full_cipher = b;
    repeat (100) tick();
    n_checks++; if (fd_cyc.size() !== 1) begin n_fail++; $display("FAIL held_frames: got %0d want 1", fd_cyc.size()); end
    n_checks++; if (mw.size() !== 22) begin n_fail++; $display("FAIL held_words: got %0d want 22", mw.size()); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL held_overrun: got %b want 0", overrun); end
    cipher_done = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_overrun();
    logic [CW-1:0] b, b2;
    logic [63:0]   m;
    bit            ok;
    rand_bundle(b);
    rand_bundle(b2);
    clear_mon();
    s_if.out_ready = 1'b1;
    cipher_done = 1'b1; full_cipher = b;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (mw.size() >= 10) break;
    end
    cipher_done = 1'b0; full_cipher = b2;
    tick();
    cipher_done = 1'b1;
    wait_fd(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovr_timeout: got no frame_done want frame_done"); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    repeat (30) tick();
    n_checks++; if (mw.size() !== 22 || fd_cyc.size() !== 1) begin n_fail++; $display("FAIL ovr_single_frame: got %0d words %0d frames want 22 1", mw.size(), fd_cyc.size()); end
    if (mw.size() == 22) begin
      for (int i = 1; i < 22; i++) begin
        m = model_word(1024'(b), CW, WW, i - 1);
        n_checks++; if (mw[i] !== m[31:0]) begin n_fail++; $display("FAIL ovr_word%0d: got %h want %h", i, mw[i], m[31:0]); end
      end
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    tick();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    cipher_done = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_overrun_last_word();
    logic [CW-1:0] b;
    int            e;
    rand_bundle(b);
    clear_mon();
    s_if.out_ready = 1'b1;
    cipher_done = 1'b1; full_cipher = b; e = cyc;
    repeat (5) tick();
    cipher_done = 1'b0;
    repeat (17) tick();
    cipher_done = 1'b1; clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL last_ovr_set_wins: got %b want 1", overrun); end
    repeat (30) tick();
    n_checks++; if (mw.size() !== 22) begin n_fail++; $display("FAIL last_ovr_words: got %0d want 22", mw.size()); end
    if (mw.size() == 22) begin
      n_checks++; if (mc[21] !== e + 22 || ml[21] !== 1'b1) begin n_fail++; $display("FAIL last_ovr_timing: got cycle %0d last %b want %0d 1", mc[21], ml[21], e + 22); end
    end
    n_checks++; if ({busy, overrun} !== 2'b01) begin n_fail++; $display("FAIL last_ovr_state: got %b want 01", {busy, overrun}); end
    clear_err = 1'b1; cipher_done = 1'b0;
    tick();
    clear_err = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_midframe();
    logic [CW-1:0] b, b2;
    logic [63:0]   m;
    bit            ok;
    int            r;
    rand_bundle(b);
    rand_bundle(b2);
    clear_mon();
    s_if.out_ready = 1'b1;
    cipher_done = 1'b1; full_cipher = b;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (mw.size() >= 5) break;
    end
    cipher_done = 1'b0;
    tick();
    cipher_done = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++; if ({s_if.out_valid, s_if.out_first, s_if.out_last} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b want 000", {s_if.out_valid, s_if.out_first, s_if.out_last}); end
    n_checks++; if (s_if.out_data !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", s_if.out_data); end
    n_checks++; if ({busy, frame_done, overrun} !== 3'b000) begin n_fail++; $display("FAIL rstmid_status: got %b want 000", {busy, frame_done, overrun}); end
    full_cipher = b2;
    rst = 1'b0; r = cyc;
    clear_mon();
    wait_fd(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got no frame_done want frame_done"); end
    n_checks++; if (mw.size() !== 22) begin n_fail++; $display("FAIL rstmid_count: got %0d want 22", mw.size()); end
    if (mw.size() == 22) begin
      n_checks++; if (mc[0] !== r + 1 || mw[0] !== 32'hEC1E0054) begin n_fail++; $display("FAIL rstmid_restart: got cycle %0d word %h want %0d ec1e0054", mc[0], mw[0], r + 1); end
      for (int i = 1; i < 22; i++) begin
        m = model_word(1024'(b2), CW, WW, i - 1);
        n_checks++; if (mw[i] !== m[31:0]) begin n_fail++; $display("FAIL rstmid_word%0d: got %h want %h", i, mw[i], m[31:0]); end
      end
    end
    cipher_done = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_padding();
    logic [P_CW-1:0] pb;
    logic [63:0]     pw[$];
    logic [63:0]     m;
    for (int i = 0; i < P_CW / 32; i++) pb[i*32 +: 32] = $urandom();
    p_if.out_ready = 1'b1;
    p_cipher_done = 1'b1; p_full = pb;
    for (int i = 0; i < 40; i++) begin
      if (p_if.out_valid && p_if.out_ready) pw.push_back(p_if.out_data);
      tick();
    end
    n_checks++; if (pw.size() !== 8) begin n_fail++; $display("FAIL pad_count: got %0d want 8", pw.size()); end
    if (pw.size() == 8) begin
      n_checks++; if (pw[0] !== 64'h0000_0000_EC1E_0038) begin n_fail++; $display("FAIL pad_header: got %h want 00000000ec1e0038", pw[0]); end
      n_checks++; if (pw[7][31:0] !== 32'h0) begin n_fail++; $display("FAIL pad_zero_lsbs: got %h want 00000000", pw[7][31:0]); end
      for (int i = 1; i < 8; i++) begin
        m = model_word(1024'(pb), P_CW, P_WW, i - 1);
        n_checks++; if (pw[i] !== m) begin n_fail++; $display("FAIL pad_word%0d: got %h want %h", i, pw[i], m); end
      end
    end
    n_checks++; if ({p_busy, p_overrun} !== 2'b00) begin n_fail++; $display("FAIL pad_idle: got %b want 00", {p_busy, p_overrun}); end
    p_cipher_done = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_frame_ordering();
    test_back_pressure();
    test_held_level();
    test_overrun();
    test_overrun_last_word();
    test_reset_midframe();
    test_padding();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
